// File: rtl/sort_engine_arbiter.sv
// Shares one sort engine between N_PORTS packet sources: packet-granular arbitration in front,
// tag-FIFO routing of results behind. Define SORT_ENGINE_ARB_FIXED_PRIO_EN for fixed priority.
module sort_engine_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int DWIDTH    = 8,
  parameter int TAG_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_PORTS-1:0]        req_val_i,
  input  logic [N_PORTS*DWIDTH-1:0] req_data_i,
  input  logic [N_PORTS-1:0]        req_sop_i,
  input  logic [N_PORTS-1:0]        req_eop_i,
  output logic [N_PORTS-1:0]        req_ready_o,
  output logic                      eng_val_o,
  output logic [DWIDTH-1:0]         eng_data_o,
  output logic                      eng_sop_o,
  output logic                      eng_eop_o,
  input  logic                      eng_ready_i,
  input  logic                      eng_res_val_i,
  input  logic [DWIDTH-1:0]         eng_res_data_i,
  input  logic                      eng_res_sop_i,
  input  logic                      eng_res_eop_i,
  output logic                      eng_res_ready_o,
  output logic [N_PORTS-1:0]        rsp_val_o,
  output logic [DWIDTH-1:0]         rsp_data_o,
  output logic                      rsp_sop_o,
  output logic                      rsp_eop_o,
  input  logic [N_PORTS-1:0]        rsp_ready_i,
  output logic [N_PORTS-1:0]        gnt_o
);

  // state | meaning
  // IDLE  | no grant; arbitrate when a request is pending and the tag FIFO has room
  // XFER  | forwarding the granted port's packet to the engine until its eop beat

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] sel_idx;
  logic          sel_found;
`ifndef SORT_ENGINE_ARB_FIXED_PRIO_EN
  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;
`endif

  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          tag_full;
  logic          tag_empty;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  // Search downward so the candidate closest to the search start overwrites the others.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef SORT_ENGINE_ARB_FIXED_PRIO_EN
    for (int k = N_PORTS-1; k >= 0; k--) begin
      if (req_val_i[k]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(k);
      end
    end
`else
    cand = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % N_PORTS);
      if (req_val_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
`endif
  end

  assign tag_full  = (count == DEPTH_CNT);
  assign tag_empty = (count == '0);
  assign push = (state == XFER) & req_val_i[gidx] & eng_ready_i & req_eop_i[gidx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= '0;
      gidx  <= '0;
`ifndef SORT_ENGINE_ARB_FIXED_PRIO_EN
      last_grant <= IW'(N_PORTS-1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_found && !tag_full) begin
            state        <= XFER;
            gidx         <= sel_idx;
            gnt_o        <= '0;
            gnt_o[sel_idx] <= 1'b1;
          end
        end
        XFER: begin
          if (push) begin
            state <= IDLE;
            gnt_o <= '0;
`ifndef SORT_ENGINE_ARB_FIXED_PRIO_EN
            last_grant <= gidx;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    eng_val_o   = 1'b0;
    eng_data_o  = '0;
    eng_sop_o   = 1'b0;
    eng_eop_o   = 1'b0;
    req_ready_o = '0;
    if (state == XFER) begin
      eng_val_o         = req_val_i[gidx];
      eng_data_o        = req_data_i[gidx*DWIDTH +: DWIDTH];
      eng_sop_o         = req_sop_i[gidx];
      eng_eop_o         = req_eop_i[gidx];
      req_ready_o[gidx] = eng_ready_i;
    end
  end

  // Tag FIFO: one entry per packet handed to the engine, popped on the result's eop.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr] <= gidx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = tag_mem[rd_ptr];

  always_comb begin
    rsp_val_o       = '0;
    eng_res_ready_o = 1'b0;
    if (!tag_empty) begin
      rsp_val_o[head] = eng_res_val_i;
      eng_res_ready_o = rsp_ready_i[head];
    end
  end

  assign pop        = eng_res_val_i & eng_res_ready_o & eng_res_eop_i;
  assign rsp_data_o = eng_res_data_i;
  assign rsp_sop_o  = eng_res_sop_i;
  assign rsp_eop_o  = eng_res_eop_i;

endmodule
